// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, mux select
// values, the read data returned on a timed-out access and the grant rule.
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_ACC = 2'b01,
    DM_ACC = 2'b10
  } arb_state_e;

  localparam logic SEL_IF = 1'b0;
  localparam logic SEL_DM = 1'b1;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Data side wins a tie unless fetch has been starved long enough.
  function automatic arb_state_e arb_pick(input logic if_req,
                                          input logic dm_req,
                                          input logic starve_at_max);
    arb_state_e pick;
    pick = IDLE;
    if (if_req && dm_req) begin
      pick = starve_at_max ? IF_ACC : DM_ACC;
    end else if (if_req) begin
      pick = IF_ACC;
    end else if (dm_req) begin
      pick = DM_ACC;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants taken while fetch was waiting.
// at_max tells the arbiter that fetch must win the next tie.
module arb_starve_cnt #(
  parameter int unsigned MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] cnt_q, cnt_d;

  // Clear has priority; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arb.sv
// Arbiter/sequencer for the shared CPU memory port (fetch vs data).
// Drives the select of the external 2:1 address/data mux, holds the access
// until mem_ready, registers read data and pulses the owner's valid.
// Optional: define ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYC
// cycles without mem_ready (bus_err + valid, read data DEAD_BEEF).
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX  = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        mem_sel,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  arb_state_e  state_q, state_d;
  arb_state_e  grant;
  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        in_acc, done, abort, rearb;
  logic        starve_inc, starve_clr, starve_at_max;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bus_err_q, bus_err_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

  // Addresses go straight to the external mux; only mem_sel steers them.
  logic unused_addr;
  assign unused_addr = ^{if_addr, dm_addr};

  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  // Completion/abort detection, re-arbitration and read-data capture.
  always_comb begin
    in_acc = (state_q != IDLE);
    done   = in_acc && mem_ready;
`ifdef ARB_TIMEOUT_EN
    abort  = in_acc && !mem_ready && (tmo_q == TMO_LAST);
`else
    abort  = 1'b0;
`endif
    // Arbitrate when idle and on the finishing edge of an access, so a
    // pending request is granted back-to-back with no idle bubble.
    rearb      = !in_acc || done || abort;
    grant      = arb_pick(if_req, dm_req, starve_at_max);
    state_d    = rearb ? grant : state_q;
    starve_inc = rearb && (grant == DM_ACC) && if_req;
    starve_clr = rearb && (grant == IF_ACC);

    if_valid_d = (done || abort) && (state_q == IF_ACC);
    dm_valid_d = (done || abort) && (state_q == DM_ACC);
    if_rdata_d = if_valid_d ? (abort ? TIMEOUT_RDATA : mem_rdata) : if_rdata_q;
    dm_rdata_d = dm_valid_d ? (abort ? TIMEOUT_RDATA : mem_rdata) : dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
    tmo_d     = rearb ? '0 : tmo_q + 1'b1;
    bus_err_d = abort;
`endif
  end

  // FSM state and registered completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      tmo_q      <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q      <= tmo_d;
      bus_err_q  <= bus_err_d;
`endif
    end
  end

  // Memory-side controls decoded from the current owner; data-side
  // write controls pass through because the requester holds them stable.
  always_comb begin
    mem_sel   = (state_q == DM_ACC) ? SEL_DM : SEL_IF;
    mem_en    = (state_q != IDLE);
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      IF_ACC: begin
        mem_be = 4'hF;
      end
      DM_ACC: begin
        mem_we    = dm_we;
        mem_be    = dm_be;
        mem_wdata = dm_wdata;
      end
      default: begin
      end
    endcase
  end

  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = dm_req & ~dm_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_port_arb;

  localparam int unsigned SMAX = 3;
  localparam int unsigned TMO  = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  localparam int NONE  = 0;
  localparam int FETCH = 1;
  localparam int DATA  = 2;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        mem_sel;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: who owns the port, how long it has waited,
  // the starvation tally and the expected registered outputs.
  int          owner;
  int          wait_cnt;
  int          starve;
  logic        m_if_valid;
  logic        m_dm_valid;
  logic        m_bus_err;
  logic [31:0] m_if_rdata;
  logic [31:0] m_dm_rdata;

  mem_port_arb #(
    .STARVE_MAX  (SMAX),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_valid  (if_valid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_valid  (dm_valid),
    .dm_rdata  (dm_rdata),
    .mem_sel   (mem_sel),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner      = NONE;
    wait_cnt   = 0;
    starve     = 0;
    m_if_valid = 1'b0;
    m_dm_valid = 1'b0;
    m_bus_err  = 1'b0;
    m_if_rdata = '0;
    m_dm_rdata = '0;
  endtask

  task automatic check_model();
    check_eq("mem_sel",   32'(mem_sel),   32'(owner == DATA));
    check_eq("mem_en",    32'(mem_en),    32'(owner != NONE));
    check_eq("mem_we",    32'(mem_we),    32'((owner == DATA) && dm_we));
    check_eq("mem_be",    32'(mem_be),    (owner == FETCH) ? 32'hF : (owner == DATA) ? 32'(dm_be) : 32'h0);
    check_eq("mem_wdata", mem_wdata,      (owner == DATA) ? dm_wdata : 32'h0);
    check_eq("if_valid",  32'(if_valid),  32'(m_if_valid));
    check_eq("if_rdata",  if_rdata,       m_if_rdata);
    check_eq("dm_valid",  32'(dm_valid),  32'(m_dm_valid));
    check_eq("dm_rdata",  dm_rdata,       m_dm_rdata);
    check_eq("stall_if",  32'(stall_if),  32'(if_req && !m_if_valid));
    check_eq("stall_mem", 32'(stall_mem), 32'(dm_req && !m_dm_valid));
    check_eq("bus_err",   32'(bus_err),   32'(m_bus_err));
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_update();
    bit fin;
    bit abt;
    int pick;
    fin = (owner != NONE) && mem_ready;
    abt = TMO_EN && (owner != NONE) && !mem_ready && (wait_cnt == int'(TMO) - 1);
    m_if_valid = (fin || abt) && (owner == FETCH);
    m_dm_valid = (fin || abt) && (owner == DATA);
    m_bus_err  = abt;
    if (m_if_valid) m_if_rdata = abt ? 32'hDEAD_BEEF : mem_rdata;
    if (m_dm_valid) m_dm_rdata = abt ? 32'hDEAD_BEEF : mem_rdata;
    if ((owner == NONE) || fin || abt) begin
      if (if_req && dm_req) pick = (starve >= int'(SMAX)) ? FETCH : DATA;
      else if (if_req)      pick = FETCH;
      else if (dm_req)      pick = DATA;
      else                  pick = NONE;
      if ((pick == DATA) && if_req) starve = (starve < int'(SMAX)) ? starve + 1 : int'(SMAX);
      if (pick == FETCH) starve = 0;
      owner    = pick;
      wait_cnt = 0;
    end else begin
      wait_cnt++;
    end
  endtask

  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_be     = '0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    @(posedge clk);
    #1;
    check_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Requesters hold a request until its valid; in the valid cycle (or when
  // idle) they randomly drop or issue a fresh request.
  task automatic drive_random();
    if (!if_req || m_if_valid) begin
      if_req  = ($urandom_range(0, 3) != 0);
      if_addr = $urandom;
    end
    if (!dm_req || m_dm_valid) begin
      dm_req   = ($urandom_range(0, 3) != 0);
      dm_we    = 1'($urandom_range(0, 1));
      dm_be    = 4'($urandom_range(0, 15));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    mem_ready = ($urandom_range(0, 2) != 0);
    mem_rdata = $urandom;
  endtask

  logic [7:0] grant_pat;
  bit         seen_if;

  initial begin
    rst_n = 1'b0;
    do_reset();

    // Fetch only, zero wait: valid two cycles after the request.
    if_req    = 1'b1;
    if_addr   = 32'h0040_0000;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    #1;
    check_eq("t1_sel", 32'(mem_sel), 32'h0);
    check_eq("t1_en",  32'(mem_en),  32'h1);
    check_eq("t1_be",  32'(mem_be),  32'hF);
    tick();
    if_req = 1'b0;
    #1;
    check_eq("t1_valid", 32'(if_valid), 32'h1);
    check_eq("t1_rdata", if_rdata, 32'h0BAD_F00D);
    tick();
    mem_ready = 1'b0;
    tick();
    tick();

    // Simultaneous requests: data first, fetch follows.
    do_reset();
    if_req    = 1'b1;
    if_addr   = 32'h0040_0004;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    dm_addr   = 32'h1001_0000;
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    tick();
    #1;
    check_eq("t2_dm_first", 32'(mem_sel), 32'h1);
    tick();
    dm_req    = 1'b0;
    mem_rdata = 32'h3333_4444;
    #1;
    check_eq("t2_dm_valid", 32'(dm_valid), 32'h1);
    check_eq("t2_dm_rdata", dm_rdata, 32'h1111_2222);
    tick();
    seen_if = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (mem_en && !mem_sel) seen_if = 1'b1;
      if (if_valid) if_req = 1'b0;
      tick();
    end
    check_eq("t2_if_granted", 32'(seen_if), 32'h1);
    if_req = 1'b0;
    repeat (3) tick();

    // Both requesting continuously: three data grants, then one fetch.
    do_reset();
    if_req    = 1'b1;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h00C0_FFEE;
    grant_pat = 8'b0111_0111;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      check_eq("t3_grant_sel", 32'(mem_sel), 32'(grant_pat[i]));
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (3) tick();

    // Store with two wait cycles: controls stable, valid after ready.
    do_reset();
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_be     = 4'b0011;
    dm_addr   = 32'h1001_0040;
    dm_wdata  = 32'hCAFE_0123;
    mem_ready = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    tick();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      #1;
      check_eq("t4_we",       32'(mem_we),    32'h1);
      check_eq("t4_be",       32'(mem_be),    32'h3);
      check_eq("t4_wdata",    mem_wdata,      32'hCAFE_0123);
      check_eq("t4_stall",    32'(stall_mem), 32'h1);
      check_eq("t4_no_valid", 32'(dm_valid),  32'h0);
      tick();
    end
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("t4_valid",   32'(dm_valid),  32'h1);
    check_eq("t4_unstall", 32'(stall_mem), 32'h0);
    tick();
    tick();
    mem_ready = 1'b0;
    tick();

    // Reset in the middle of a waiting data access.
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    dm_req = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #1;
    check_eq("t5_en",       32'(mem_en),    32'h0);
    check_eq("t5_sel",      32'(mem_sel),   32'h0);
    check_eq("t5_we",       32'(mem_we),    32'h0);
    check_eq("t5_be",       32'(mem_be),    32'h0);
    check_eq("t5_dm_rdata", dm_rdata,       32'h0);
    check_eq("t5_if_rdata", if_rdata,       32'h0);
    check_eq("t5_dm_valid", 32'(dm_valid),  32'h0);
    check_eq("t5_stall",    32'(stall_mem), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) tick();

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort with bus_err, then arbitration resumes.
    do_reset();
    if_req    = 1'b1;
    if_addr   = 32'h0040_0100;
    mem_ready = 1'b0;
    tick();
    repeat (TMO) tick();
    if_req    = 1'b0;
    dm_req    = 1'b1;
    dm_we     = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_eq("t6_bus_err",  32'(bus_err),  32'h1);
    check_eq("t6_if_valid", 32'(if_valid), 32'h1);
    check_eq("t6_rdata",    if_rdata,      32'hDEAD_BEEF);
    tick();
    #1;
    check_eq("t6_resume_dm", 32'(mem_sel), 32'h1);
    dm_req = 1'b0;
    repeat (3) tick();
`endif

    // Random traffic against the reference model.
    do_reset();
    repeat (3000) begin
      drive_random();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
